demux_1to4_router: RTL
======================

Name: demux_1to4_router

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the team's registered priority 4:1 mux.
- Takes one valid/ready input stream and steers each word to one of four output channels (a, b, c, d).
- Steering is by four select bits with fixed priority a > b > c > d.
- Each channel has a one-entry holding register with its own valid/ready handshake, so one stalled channel never corrupts another.

Parameters:
- WIDTH, 4, data width of input and each output channel.
- DROP_CNT_W, 8, width of the saturating dropped-word counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  router can accept in_data this cycle.
- sel_a, sel_b, sel_c, sel_d  input  1 each  channel selects, priority a highest; sampled only on an input transfer.
- out_a, out_b, out_c, out_d  output  WIDTH each  channel holding-register data.
- out_valid_a .. out_valid_d  output  1 each  channel register holds a word.
- out_ready_a .. out_ready_d  input  1 each  downstream consumer ready.
- drop_cnt  output  DROP_CNT_W  count of words accepted with no select set.

Behaviour:
- Reset (rst_n low, asynchronous, also mid-operation):
  - All out_valid_x = 0, all out_x = 0, drop_cnt = 0.
  - Any held words are discarded.
  - in_ready is 0 while rst_n is low.
- Target decode (combinational):
  - target = a if sel_a; else b if sel_b; else c if sel_c; else d if sel_d; else NONE.
  - Multiple set selects resolve by priority; lower-priority channels are untouched.
- Drain: channel x drains in a cycle when out_valid_x & out_ready_x.
- in_ready (combinational, registered inputs plus sel and out_ready only):
  - 1 if target = NONE.
  - Else 1 if target's out_valid_x = 0 or target drains this cycle.
  - Else 0.
  - in_ready never depends on in_valid.
- Input transfer (in_valid & in_ready at posedge):
  - target x: out_x <= in_data, out_valid_x <= 1; visible one cycle after the accepting edge (latency 1).
  - target NONE: word is consumed and discarded; drop_cnt increments by 1 and saturates at all-ones (no wrap).
- Load and drain on the same edge for the same channel: new word is loaded and out_valid_x stays 1 (full throughput, one word per clock per channel).
- Drain without load: out_valid_x <= 0; out_x retains its last value.
- Stall: while out_valid_x & !out_ready_x, out_x and out_valid_x are held stable. A new word for x is back-pressured with in_ready = 0.
- Independence:
  - Channels drain concurrently and independently.
  - A stalled channel blocks only input words targeting it.
  - Words targeting other channels, or NONE, proceed.
- Select changes while in_valid = 0, or while in_ready = 0, have no state effect.
- Ordering: words to the same channel exit in acceptance order; there is no cross-channel ordering guarantee.
- Concurrent assertions (negedge-sampled, matching existing team practice):
  - A transfer with sel_a leads to out_a == past in_data on the next negedge.
  - out_valid_x & !out_ready_x implies out_x is stable on the next negedge.
  - drop_cnt never decreases except at reset.

Test Plan:
1. Reset, then in_data=4'h5, sel_a=1, in_valid=1 for one cycle, all out_ready=1 -> next cycle out_a=5, out_valid_a=1; following cycle out_valid_a=0.
2. sel_a=0, sel_b=1, sel_c=1, in_data=4'h9 -> out_b=9, out_valid_b=1; out_valid_c stays 0 (priority).
3. out_ready_c=0; send 4'h3 to c, then 4'h7 to c -> out_c=3 held, in_ready=0 on the second word. Raise out_ready_c -> same edge drains 3 and loads 7; out_valid_c stays 1, then out_c=7.
4. With channel c stalled full, send 4'hA with sel_d=1 -> in_ready=1, out_d=A next cycle; out_c unchanged.
5. 300 words with all selects 0 -> drop_cnt ends at 255, no out_valid ever set.
6. out_valid_a=1 held (out_ready_a=0); assert rst_n=0 mid-cycle -> out_valid_a=0 and out_a=0 immediately, before the next clk edge; drop_cnt=0.

Source files
------------

// File: rtl/demux_1to4_router_if.sv
// Handshake bundle for the 1-to-4 router: one valid/ready input stream with
// channel selects, and four valid/ready output channels.
interface demux_1to4_router_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel_a, sel_b, sel_c, sel_d;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic             out_valid_a, out_valid_b, out_valid_c, out_valid_d;
    logic             out_ready_a, out_ready_b, out_ready_c, out_ready_d;

    modport master (
        output in_data, in_valid, sel_a, sel_b, sel_c, sel_d,
               out_ready_a, out_ready_b, out_ready_c, out_ready_d,
        input  in_ready, out_a, out_b, out_c, out_d,
               out_valid_a, out_valid_b, out_valid_c, out_valid_d
    );

    modport slave (
        input  in_data, in_valid, sel_a, sel_b, sel_c, sel_d,
               out_ready_a, out_ready_b, out_ready_c, out_ready_d,
        output in_ready, out_a, out_b, out_c, out_d,
               out_valid_a, out_valid_b, out_valid_c, out_valid_d
    );
endinterface

// File: rtl/demux_1to4_router.sv
// Registered 1-to-4 demux: priority-selected steering into four independent
// one-entry holding registers, with a saturating count of unsteered words.
module demux_1to4_router #(
    parameter int WIDTH      = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1to4_router_if.slave    bus,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    logic [3:0]            sel, out_rdy, tgt, load, drain;
    logic [3:0]            valid_q, valid_d;
    logic [WIDTH-1:0]      data_q [4];
    logic [WIDTH-1:0]      data_d [4];
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  tgt_none, in_ready, xfer;

    assign sel     = {bus.sel_d, bus.sel_c, bus.sel_b, bus.sel_a};
    assign out_rdy = {bus.out_ready_d, bus.out_ready_c, bus.out_ready_b, bus.out_ready_a};

    always_comb begin
        tgt = 4'b0000;
        if (sel[0])      tgt = 4'b0001;
        else if (sel[1]) tgt = 4'b0010;
        else if (sel[2]) tgt = 4'b0100;
        else if (sel[3]) tgt = 4'b1000;
    end

    assign tgt_none = (tgt == 4'b0000);
    assign drain    = valid_q & out_rdy;
    // Only the targeted channel can back-pressure; a draining slot accepts on the same edge.
    assign in_ready = rst_n & (tgt_none | ~|(tgt & valid_q & ~drain));
    assign xfer     = bus.in_valid & in_ready;
    assign load     = xfer ? tgt : 4'b0000;

    always_comb begin
        valid_d = (valid_q & ~drain) | load;
        drop_d  = drop_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = load[i] ? bus.in_data : data_q[i];
        end
        if (xfer && tgt_none && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            drop_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            drop_q  <= drop_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_a       = data_q[0];
    assign bus.out_b       = data_q[1];
    assign bus.out_c       = data_q[2];
    assign bus.out_d       = data_q[3];
    assign bus.out_valid_a = valid_q[0];
    assign bus.out_valid_b = valid_q[1];
    assign bus.out_valid_c = valid_q[2];
    assign bus.out_valid_d = valid_q[3];
    assign drop_cnt        = drop_q;

    a_load_a: assert property (@(negedge clk) disable iff (!rst_n)
        $past(bus.in_valid && in_ready && bus.sel_a) |-> (bus.out_a == $past(bus.in_data)));

    a_stall_stable: assert property (@(negedge clk) disable iff (!rst_n)
        $past(valid_q & ~out_rdy) == 4'b0000
        || ((($past(valid_q & ~out_rdy)) & ~valid_q) == 4'b0000
            && (!$past(valid_q[0] & ~out_rdy[0]) || $stable(data_q[0]))
            && (!$past(valid_q[1] & ~out_rdy[1]) || $stable(data_q[1]))
            && (!$past(valid_q[2] & ~out_rdy[2]) || $stable(data_q[2]))
            && (!$past(valid_q[3] & ~out_rdy[3]) || $stable(data_q[3]))));

    a_drop_mono: assert property (@(negedge clk) disable iff (!rst_n)
        drop_q >= $past(drop_q));
endmodule
